// File: rtl/modsq_iter_host.sv
// modsq_iter_host: host sequencer that squares a seed T times through an external squarer,
// carry-normalising each redundant result. Optional sq_valid watchdog: `define MODSQ_HOST_TIMEOUT_EN.
`timescale 1ns/1ps
module modsq_iter_host #(
  parameter int MOD_LEN        = 1024,
  parameter int WORD_LEN       = 16,
  parameter int NUM_ELEMENTS   = MOD_LEN / WORD_LEN + 2,
  parameter int COEF_W         = 17,
  parameter int ITER_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               job_valid,
  output logic                               job_ready,
  input  logic [MOD_LEN-1:0]                 job_x,
  input  logic [ITER_W-1:0]                  job_iters,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [MOD_LEN-1:0]                 res_y,
  output logic [ITER_W-1:0]                  res_iters_done,
  output logic [1:0]                         res_err,
  output logic                               sq_start,
  output logic [MOD_LEN-1:0]                 sq_in,
  input  logic [NUM_ELEMENTS*2*WORD_LEN-1:0] sq_out,
  input  logic                               sq_valid
);

  localparam int FIELD_W = 2 * WORD_LEN;
  localparam int ACC_W   = COEF_W + 2;
  localparam int CARRY_W = ACC_W - WORD_LEN;
  localparam int NORM_W  = NUM_ELEMENTS * WORD_LEN;
  localparam int IDX_W   = $clog2(NUM_ELEMENTS + 1);
  localparam int PAD_W   = FIELD_W - COEF_W;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

  logic [2:0]                     state_r;
  logic [ITER_W-1:0]              iters_r;
  logic [ITER_W-1:0]              done_r;
  logic [ITER_W-1:0]              done_inc_s;
  logic [NUM_ELEMENTS*COEF_W-1:0] coef_r;
  logic [NUM_ELEMENTS*COEF_W-1:0] coef_cap_s;
  logic [NUM_ELEMENTS*PAD_W-1:0]  unused_field_s;
  logic [NORM_W-1:0]              norm_r;
  logic [NORM_W-1:0]              norm_next_s;
  logic [ACC_W-1:0]               acc_s;
  logic [CARRY_W-1:0]             carry_r;
  logic [IDX_W-1:0]               idx_r;
  logic                           last_s;
  logic                           ovf_s;

  // Only the low COEF_W bits of each 2*WORD_LEN field carry information
  for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_coef
    assign coef_cap_s[g*COEF_W +: COEF_W]   = sq_out[g*FIELD_W +: COEF_W];
    assign unused_field_s[g*PAD_W +: PAD_W] = sq_out[g*FIELD_W+COEF_W +: PAD_W];
  end

`ifdef MODSQ_HOST_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] wait_cnt_r;
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
`endif

  // Normalisation step: coef_r and norm_r are shift registers, so coefficient j is always at the bottom
  always_comb begin
    acc_s       = ACC_W'(carry_r) + ACC_W'(coef_r[COEF_W-1:0]);
    norm_next_s = {acc_s[WORD_LEN-1:0], norm_r[NORM_W-1:WORD_LEN]};
    done_inc_s  = done_r + ITER_W'(1);
    last_s      = (idx_r == IDX_W'(NUM_ELEMENTS - 1));
    ovf_s       = (acc_s[ACC_W-1:WORD_LEN] != {CARRY_W{1'b0}}) ||
                  (norm_next_s[NORM_W-1:MOD_LEN] != {(NORM_W-MOD_LEN){1'b0}});
  end

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= S_IDLE;
      job_ready      <= 1'b1;
      res_valid      <= 1'b0;
      res_y          <= '0;
      res_iters_done <= '0;
      res_err        <= ERR_OK;
      sq_start       <= 1'b0;
      sq_in          <= '0;
      iters_r        <= '0;
      done_r         <= '0;
      coef_r         <= '0;
      norm_r         <= '0;
      carry_r        <= '0;
      idx_r          <= '0;
`ifdef MODSQ_HOST_TIMEOUT_EN
      wait_cnt_r     <= '0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            job_ready <= 1'b0;
            iters_r   <= job_iters;
            done_r    <= '0;
            sq_in     <= job_x;
            if (job_iters != {ITER_W{1'b0}}) begin
              sq_start <= 1'b1;
              state_r  <= S_ISSUE;
            end else begin
              res_y          <= job_x;
              res_iters_done <= '0;
              res_err        <= ERR_OK;
              res_valid      <= 1'b1;
              state_r        <= S_RESP;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_ISSUE: begin
          sq_start <= 1'b0;
`ifdef MODSQ_HOST_TIMEOUT_EN
          wait_cnt_r <= '0;
`endif
          state_r  <= S_WAIT;
        end
        S_WAIT: begin
          if (sq_valid) begin
            coef_r  <= coef_cap_s;
            carry_r <= '0;
            idx_r   <= '0;
            state_r <= S_NORM;
          end
`ifdef MODSQ_HOST_TIMEOUT_EN
          else if (wait_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
            res_y          <= sq_in;
            res_iters_done <= done_r;
            res_err        <= ERR_TOUT;
            res_valid      <= 1'b1;
            state_r        <= S_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
          end
`else
          else begin
            state_r <= S_WAIT;
          end
`endif
        end
        S_NORM: begin
          norm_r  <= norm_next_s;
          coef_r  <= coef_r >> COEF_W;
          carry_r <= acc_s[ACC_W-1:WORD_LEN];
          idx_r   <= idx_r + IDX_W'(1);
          if (last_s) begin
            done_r <= done_inc_s;
            // Overflow keeps the previous operand as the reported result
            if (ovf_s) begin
              res_y          <= sq_in;
              res_iters_done <= done_inc_s;
              res_err        <= ERR_OVF;
              res_valid      <= 1'b1;
              state_r        <= S_RESP;
            end else begin
              sq_in <= norm_next_s[MOD_LEN-1:0];
              if (done_inc_s < iters_r) begin
                sq_start <= 1'b1;
                state_r  <= S_ISSUE;
              end else begin
                res_y          <= norm_next_s[MOD_LEN-1:0];
                res_iters_done <= done_inc_s;
                res_err        <= ERR_OK;
                res_valid      <= 1'b1;
                state_r        <= S_RESP;
              end
            end
          end else begin
            state_r <= S_NORM;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state_r   <= S_IDLE;
          end else begin
            state_r <= S_RESP;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          job_ready <= 1'b1;
          res_valid <= 1'b0;
          sq_start  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modsq_iter_host.sv
// Bench for modsq_iter_host: behavioural squarer plus a big-integer reference of the iteration,
// with directed pins and randomized jobs.
`timescale 1ns/1ps
module tb_modsq_iter_host;
  localparam int ML = 64;
  localparam int WL = 16;
  localparam int NE = 6;
  localparam int CW = 17;
  localparam int IW = 32;
  localparam int TO = 100;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              job_valid;
  logic              job_ready;
  logic [ML-1:0]     job_x;
  logic [IW-1:0]     job_iters;
  logic              res_valid;
  logic              res_ready;
  logic [ML-1:0]     res_y;
  logic [IW-1:0]     res_iters_done;
  logic [1:0]        res_err;
  logic              sq_start;
  logic [ML-1:0]     sq_in;
  logic [NE*32-1:0]  sq_out;
  logic              sq_valid;

  always #5 clk = ~clk;

  modsq_iter_host #(.MOD_LEN(ML), .WORD_LEN(WL), .NUM_ELEMENTS(NE), .COEF_W(CW),
                    .ITER_W(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_iters(job_iters), .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_iters_done(res_iters_done), .res_err(res_err),
    .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out), .sq_valid(sq_valid));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // squarer programming: mode 0 table, 1 echo sq_in, 2 silent
  int sq_mode = 0;
  int lat = 1;
  int sq_idx = 0;
  logic [CW-1:0] ctab [16][NE];

  // reference expectations
  logic [ML-1:0] exp_op_q[$];
  logic [ML-1:0] exp_y;
  logic [IW-1:0] exp_done;
  logic [1:0]    exp_err;
  bit            job_active = 1'b0;
  bit            have_start = 1'b0;
  int            last_start = 0;
  int            n_starts = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [127:0] coef_sum(input int it);
    logic [127:0] s;
    s = '0;
    for (int j = 0; j < NE; j++) s = s + (128'(ctab[it][j]) << (WL * j));
    return s;
  endfunction

  // behavioural squarer: answers lat cycles after a start, with junk in the unused field bits
  initial begin : squarer
    logic [ML-1:0] op;
    logic [CW-1:0] c;
    int it;
    sq_valid = 1'b0;
    sq_out = '0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && sq_start === 1'b1 && sq_mode != 2) begin
        op = sq_in;
        it = sq_idx;
        sq_idx++;
        repeat (lat) @(negedge clk);
        for (int j = 0; j < NE; j++) begin
          if (sq_mode == 1) c = (j < ML / WL) ? CW'(op[j*WL +: WL]) : 17'd0;
          else c = ctab[it][j];
          sq_out[j*32 +: 32] = {15'($urandom), c};
        end
        sq_valid = 1'b1;
        @(negedge clk);
        sq_valid = 1'b0;
        for (int j = 0; j < NE; j++) sq_out[j*32 +: 32] = $urandom;
      end
    end
  end

  // compare process: operands at each start, start spacing, and result fields while res_valid
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (sq_start === 1'b1) begin
          n_starts++;
          if (exp_op_q.size() == 0) report_fail("sq_start with no iteration pending");
          else check("sq_in at start", 128'(sq_in), 128'(exp_op_q.pop_front()));
          if (have_start) check("start spacing", 128'(cyc - last_start), 128'(1 + lat + NE));
          have_start = 1'b1;
          last_start = cyc;
        end
        if (res_valid === 1'b1) begin
          if (!job_active) report_fail("res_valid with no job");
          else begin
            check("res_y", 128'(res_y), 128'(exp_y));
            check("res_iters_done", 128'(res_iters_done), 128'(exp_done));
            check("res_err", 128'(res_err), 128'(exp_err));
          end
        end
      end
    end
  end

  task automatic run_job(input logic [ML-1:0] x, input int t, input int mode, input int l,
                         input int hold);
    logic [ML-1:0]  y;
    logic [127:0]   v;
    int             acc_cyc;
    int             k;
    bit             stop;
    sq_mode = mode;
    lat = l;
    sq_idx = 0;
    have_start = 1'b0;
    n_starts = 0;
    exp_op_q.delete();
    y = x;
    exp_err = 2'b00;
    exp_done = IW'(t);
    stop = 1'b0;
    if (mode == 2) begin
      if (t > 0) exp_op_q.push_back(x);
      exp_done = '0;
      exp_err = 2'b10;
    end else begin
      for (int i = 0; i < t && !stop; i++) begin
        exp_op_q.push_back(y);
        if (mode == 0) begin
          v = coef_sum(i);
          if (v[127:ML] != '0) begin
            exp_err = 2'b01;
            exp_done = IW'(i + 1);
            stop = 1'b1;
          end else begin
            y = v[ML-1:0];
          end
        end
      end
    end
    exp_y = y;
    check("job_ready before job", 128'(job_ready), 128'(1));
    job_x = x;
    job_iters = IW'(t);
    job_valid = 1'b1;
    job_active = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    acc_cyc = cyc;
    check("job_ready while busy", 128'(job_ready), 128'(0));
    for (k = 0; k < 20000 && res_valid !== 1'b1; k++) @(negedge clk);
    if (res_valid !== 1'b1) report_fail("result never arrived");
    else if (mode == 2) check("timeout distance from WAIT entry", 128'(cyc - last_start - 1), 128'(TO));
    else check("result latency", 128'(cyc - acc_cyc), 128'(int'(exp_done) * (1 + l + NE)));
    repeat (hold) @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    job_active = 1'b0;
    check("res_valid after consume", 128'(res_valid), 128'(0));
    check("job_ready after consume", 128'(job_ready), 128'(1));
    check("all iterations issued", 128'(exp_op_q.size()), 128'(0));
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) for (int j = 0; j < NE; j++) ctab[i][j] = '0;
  endtask

  task automatic rand_tab();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < NE; j++) begin
        if (j < 3) ctab[i][j] = CW'($urandom);
        else if (j == 3) ctab[i][j] = {1'($urandom_range(0, 7) == 0), 16'($urandom)};
        else ctab[i][j] = ($urandom_range(0, 9) == 0) ? 17'd1 : 17'd0;
      end
    end
  endtask

  initial begin : main
    logic [ML-1:0] xr;
    reset_n = 1'b0;
    job_valid = 1'b0;
    job_x = '0;
    job_iters = '0;
    res_ready = 1'b0;
    clear_tab();
    repeat (3) @(negedge clk);
    check("reset job_ready", 128'(job_ready), 128'(1));
    check("reset res_valid", 128'(res_valid), 128'(0));
    check("reset sq_start", 128'(sq_start), 128'(0));
    check("reset sq_in", 128'(sq_in), 128'(0));
    check("reset res_y", 128'(res_y), 128'(0));
    reset_n = 1'b1;
    @(negedge clk);

    run_job(64'h1234, 0, 0, 1, 2);
    check("T0 starts", 128'(n_starts), 128'(0));

    clear_tab();
    ctab[0][0] = 17'h1FFFF;
    ctab[0][1] = 17'h00001;
    run_job({$urandom, $urandom}, 1, 0, 3, 1);
    check("pin T1 model res_y", 128'(exp_y), 128'(64'h2FFFF));

    run_job({$urandom, $urandom}, 3, 1, 10, 0);
    check("T3 echo starts", 128'(n_starts), 128'(3));

    clear_tab();
    ctab[0][0] = 17'h0ABCD;
    ctab[0][1] = 17'h00001;
    ctab[1][0] = 17'h00005;
    ctab[1][4] = 17'h00001;
    run_job({$urandom, $urandom}, 5, 0, 2, 6);
    check("pin ovf model res_y", 128'(exp_y), 128'(64'h1ABCD));
    check("pin ovf model done", 128'(exp_done), 128'(2));
    check("pin ovf model err", 128'(exp_err), 128'(1));
    check("ovf starts", 128'(n_starts), 128'(2));

    for (int r = 0; r < 12; r++) begin
      rand_tab();
      run_job({$urandom, $urandom}, $urandom_range(0, 6), $urandom_range(0, 1),
              $urandom_range(1, 6), $urandom_range(0, 3));
    end

`ifdef MODSQ_HOST_TIMEOUT_EN
    run_job({$urandom, $urandom}, 2, 2, 1, 1);
`endif

    // reset while the host waits on a silent squarer
    xr = {$urandom, $urandom} | 64'h1;
    sq_mode = 2;
    lat = 1;
    sq_idx = 0;
    have_start = 1'b0;
    n_starts = 0;
    exp_op_q.delete();
    exp_op_q.push_back(xr);
    job_x = xr;
    job_iters = 32'd2;
    job_valid = 1'b1;
    job_active = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("start before mid-WAIT reset", 128'(n_starts), 128'(1));
    reset_n = 1'b0;
    #1;
    check("async reset job_ready", 128'(job_ready), 128'(1));
    check("async reset res_valid", 128'(res_valid), 128'(0));
    check("async reset sq_start", 128'(sq_start), 128'(0));
    check("async reset sq_in", 128'(sq_in), 128'(0));
    check("async reset res_y", 128'(res_y), 128'(0));
    check("async reset res_iters_done", 128'(res_iters_done), 128'(0));
    check("async reset res_err", 128'(res_err), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    job_active = 1'b0;
    exp_op_q.delete();
    @(negedge clk);

    run_job(64'h0000_5555_0000_00AA, 2, 1, 2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
